// File: rtl/rx_pkg.sv
// ---------------------------------------------------------------------------
// rx_pkg
// Shared definitions for the RX collector:
//   - slot_state_e : per-switch tracking slot state (IDLE / WAIT / DONE)
//   - WR / RD      : encoding of the scheduler's wr_rd_s signal
//   - frame layout : field widths plus helper functions that give each field's
//                    bit position for any FRAME_WIDTH / W_WIDTH combination.
//                    The OPID_MSB..TO_BIT localparams are the default
//                    32-bit / 8-bit values.
// No ports (package).
// ---------------------------------------------------------------------------
package rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } slot_state_e;

  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;

  localparam int OPID_W = 8;
  localparam int IDX_W  = 3;

  // Frame is packed MSB first: op_id, addr, data, slot index, to_flag, zero fill.
  function automatic int opid_msb(input int fw);
    return fw - 1;
  endfunction

  function automatic int addr_lsb(input int fw, input int w);
    return fw - OPID_W - w;
  endfunction

  function automatic int data_lsb(input int fw, input int w);
    return addr_lsb(fw, w) - w;
  endfunction

  function automatic int idx_lsb(input int fw, input int w);
    return data_lsb(fw, w) - IDX_W;
  endfunction

  function automatic int to_bit(input int fw, input int w);
    return idx_lsb(fw, w) - 1;
  endfunction

  localparam int OPID_MSB = opid_msb(32);
  localparam int ADDR_LSB = addr_lsb(32, 8);
  localparam int DATA_LSB = data_lsb(32, 8);
  localparam int IDX_LSB  = idx_lsb(32, 8);
  localparam int TO_BIT   = to_bit(32, 8);

endpackage

// File: rtl/rx_collector_if.sv
// ---------------------------------------------------------------------------
// rx_collector_if
// Bundles the collector's bus signals.
//   Scheduler side : sel_en, addr, wr_rd_s, op_id (in), sw_busy, err_overrun (out)
//   Switch side    : rd_valid, rd_data (in)
//   Response FIFO  : resp_full (in), resp_wr_en, resp_frame (out)
// Modports: master = environment driving the collector, slave = the collector.
// ---------------------------------------------------------------------------
interface rx_collector_if #(
  parameter int NUM_SW_INST = 5,
  parameter int W_WIDTH     = 8,
  parameter int FRAME_WIDTH = 32
);
  logic [NUM_SW_INST-1:0]         sel_en;
  logic [W_WIDTH-1:0]             addr;
  logic                           wr_rd_s;
  logic [7:0]                     op_id;
  logic [NUM_SW_INST-1:0]         rd_valid;
  logic [NUM_SW_INST*W_WIDTH-1:0] rd_data;
  logic                           resp_full;
  logic                           resp_wr_en;
  logic [FRAME_WIDTH-1:0]         resp_frame;
  logic [NUM_SW_INST-1:0]         sw_busy;
  logic [NUM_SW_INST-1:0]         err_overrun;

  modport master (
    output sel_en, addr, wr_rd_s, op_id, rd_valid, rd_data, resp_full,
    input  resp_wr_en, resp_frame, sw_busy, err_overrun
  );

  modport slave (
    input  sel_en, addr, wr_rd_s, op_id, rd_valid, rd_data, resp_full,
    output resp_wr_en, resp_frame, sw_busy, err_overrun
  );
endinterface

// File: rtl/rx_collector_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter. Searches req upward from the pointer (modulo N) and
// reports the first hit as a one-hot grant plus its index. When advance is
// high the pointer moves to grant_idx+1 mod N; otherwise it holds.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset (pointer -> 0)
//   req[N]      : requesting slots
//   advance     : the current grant is being consumed this cycle
//   grant[N]    : one-hot grant (all zero when nothing requests)
//   grant_idx   : index of the granted slot (0 when nothing requests)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N  = 5,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);
  logic [IW-1:0] ptr_reg;
  logic [IW-1:0] ptr_next;
  logic          found;
  int            cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr_reg) + k) % N;
      if (!found && req[cand]) begin
        found        = 1'b1;
        grant_idx    = IW'(cand);
        grant[cand]  = 1'b1;
      end
    end
    ptr_next = ptr_reg;
    if (advance && found) begin
      ptr_next = (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end
endmodule

// File: rtl/rx_collector.sv
// ---------------------------------------------------------------------------
// rx_collector
// Tracks one outstanding read per switch instance, turns each read result (or
// a timeout) into a response frame and writes it to the response FIFO.
// Ports:
//   clk                 : clock, rising edge
//   rst_n               : synchronous active-low reset
//   bus (slave modport) :
//     sel_en, addr, wr_rd_s, op_id : accesses issued by the scheduler
//     rd_valid, rd_data            : per-switch read returns
//     resp_full                    : response FIFO full (stalls output)
//     resp_wr_en, resp_frame       : registered FIFO write port
//     sw_busy                      : slot has a read in flight / frame pending
//     err_overrun                  : sticky, access hit a non-idle slot
// ---------------------------------------------------------------------------
module rx_collector
  import rx_pkg::*;
#(
  parameter int NUM_SW_INST = 5,
  parameter int W_WIDTH     = 8,
  parameter int FRAME_WIDTH = 32,
  parameter int TIMEOUT     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  rx_collector_if.slave bus
);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam int GI_W  = (NUM_SW_INST > 1) ? $clog2(NUM_SW_INST) : 1;
  localparam int F_OPID_MSB = opid_msb(FRAME_WIDTH);
  localparam int F_ADDR_LSB = addr_lsb(FRAME_WIDTH, W_WIDTH);
  localparam int F_DATA_LSB = data_lsb(FRAME_WIDTH, W_WIDTH);
  localparam int F_IDX_LSB  = idx_lsb(FRAME_WIDTH, W_WIDTH);
  localparam int F_TO_BIT   = to_bit(FRAME_WIDTH, W_WIDTH);

  logic [NUM_SW_INST-1:0] done_vec;
  logic [NUM_SW_INST-1:0] grant;
  logic [NUM_SW_INST-1:0] busy_vec;
  logic [NUM_SW_INST-1:0] overrun_vec;
  logic [GI_W-1:0]        grant_idx;
  logic                   advance;
  logic [FRAME_WIDTH-1:0] slot_frame [NUM_SW_INST];
  logic                   resp_wr_en_reg;
  logic [FRAME_WIDTH-1:0] resp_frame_reg;

  // A frame leaves only when some slot is DONE and the FIFO can take it.
  assign advance = (|done_vec) && !bus.resp_full;

  rr_arbiter #(.N(NUM_SW_INST)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (done_vec),
    .advance   (advance),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  generate
    for (genvar gi = 0; gi < NUM_SW_INST; gi++) begin : g_slot
      slot_state_e            state_reg, state_next;
      logic [TMR_W-1:0]       timer_reg;
      logic [7:0]             op_id_reg;
      logic [W_WIDTH-1:0]     addr_reg;
      logic [W_WIDTH-1:0]     data_reg;
      logic                   to_reg;
      logic                   busy_reg;
      logic                   overrun_reg;
      logic                   rd_strobe;
      logic                   expired;
      logic                   granted;
      logic [FRAME_WIDTH-1:0] frame;

      assign rd_strobe = bus.sel_en[gi] && (bus.wr_rd_s == RD);
      assign expired   = (timer_reg == TMR_W'(TIMEOUT - 1));
      assign granted   = grant[gi] && advance;

      always_comb begin
        state_next = state_reg;
        case (state_reg)
          IDLE:    if (rd_strobe) state_next = WAIT;
          WAIT:    if (bus.rd_valid[gi] || expired) state_next = DONE;
          DONE:    if (granted) state_next = IDLE;
          default: state_next = IDLE;
        endcase
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_reg   <= IDLE;
          timer_reg   <= '0;
          op_id_reg   <= '0;
          addr_reg    <= '0;
          data_reg    <= '0;
          to_reg      <= 1'b0;
          busy_reg    <= 1'b0;
          overrun_reg <= 1'b0;
        end else begin
          state_reg <= state_next;
          // Busy spans the whole pending period and stays up through the
          // cycle in which the slot's frame appears on resp_wr_en.
          busy_reg  <= (state_reg != IDLE) || (state_next != IDLE);
          if (bus.sel_en[gi] && state_reg != IDLE) begin
            overrun_reg <= 1'b1;
          end
          case (state_reg)
            IDLE: begin
              if (rd_strobe) begin
                op_id_reg <= bus.op_id;
                addr_reg  <= bus.addr;
                timer_reg <= '0;
              end
            end
            WAIT: begin
              // rd_valid takes priority over an expiring timer.
              if (bus.rd_valid[gi]) begin
                data_reg <= bus.rd_data[gi*W_WIDTH +: W_WIDTH];
                to_reg   <= 1'b0;
              end else if (expired) begin
                data_reg <= '0;
                to_reg   <= 1'b1;
              end else begin
                timer_reg <= timer_reg + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end

      always_comb begin
        frame                                  = '0;
        frame[F_OPID_MSB -: OPID_W]            = op_id_reg;
        frame[F_ADDR_LSB +: W_WIDTH]           = addr_reg;
        frame[F_DATA_LSB +: W_WIDTH]           = data_reg;
        frame[F_IDX_LSB +: IDX_W]              = IDX_W'(gi);
        frame[F_TO_BIT]                        = to_reg;
      end

      assign slot_frame[gi]  = frame;
      assign done_vec[gi]    = (state_reg == DONE);
      assign busy_vec[gi]    = busy_reg;
      assign overrun_vec[gi] = overrun_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_wr_en_reg <= 1'b0;
      resp_frame_reg <= '0;
    end else begin
      resp_wr_en_reg <= advance;
      if (advance) begin
        resp_frame_reg <= slot_frame[grant_idx];
      end
    end
  end

  assign bus.resp_wr_en  = resp_wr_en_reg;
  assign bus.resp_frame  = resp_frame_reg;
  assign bus.sw_busy     = busy_vec;
  assign bus.err_overrun = overrun_vec;
endmodule

// File: tb/tb_rx_collector.sv
// ---------------------------------------------------------------------------
// tb_rx_collector
// Directed scenarios plus a randomized run against a reference model that
// tracks each switch as "waiting" / "ready" with an age count, a round-robin
// pointer, and builds frames with plain shifts.
// ---------------------------------------------------------------------------
module tb_rx_collector;
  localparam int N  = 5;
  localparam int W  = 8;
  localparam int FW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rx_collector_if #(.NUM_SW_INST(N), .W_WIDTH(W), .FRAME_WIDTH(FW)) bus ();

  rx_collector #(.NUM_SW_INST(N), .W_WIDTH(W), .FRAME_WIDTH(FW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  bit         m_pend [N];
  bit         m_ready[N];
  bit         m_ovr  [N];
  int         m_age  [N];
  bit [7:0]   m_op   [N];
  bit [W-1:0] m_addr [N];
  bit [W-1:0] m_data [N];
  bit         m_to   [N];
  int         m_rr;
  bit         exp_wr;
  bit [FW-1:0] exp_frame;
  bit [N-1:0] exp_busy;
  bit [N-1:0] exp_ovr;

  function automatic bit [FW-1:0] model_frame(input int s);
    return (32'(m_op[s]) << 24) | (32'(m_addr[s]) << 16) | (32'(m_data[s]) << 8) |
           (32'(s) << 5) | (32'(m_to[s]) << 4);
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit was_busy[N];
    int g;
    if (!rst_n) begin
      for (int s = 0; s < N; s++) begin
        m_pend[s] = 0; m_ready[s] = 0; m_ovr[s] = 0; m_age[s] = 0;
        m_op[s] = 0; m_addr[s] = 0; m_data[s] = 0; m_to[s] = 0;
      end
      m_rr = 0; exp_wr = 0; exp_frame = '0; exp_busy = '0; exp_ovr = '0;
      return;
    end
    for (int s = 0; s < N; s++) was_busy[s] = m_pend[s] || m_ready[s];
    g = -1;
    if (!bus.resp_full) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && m_ready[(m_rr + k) % N]) g = (m_rr + k) % N;
      end
    end
    exp_wr = (g >= 0);
    if (g >= 0) begin
      exp_frame  = model_frame(g);
      m_ready[g] = 0;
      m_rr       = (g + 1) % N;
    end
    for (int s = 0; s < N; s++) begin
      if (m_pend[s]) begin
        if (bus.rd_valid[s]) begin
          m_pend[s] = 0; m_ready[s] = 1; m_data[s] = bus.rd_data[s*W +: W]; m_to[s] = 0;
        end else if (m_age[s] + 1 == TO) begin
          m_pend[s] = 0; m_ready[s] = 1; m_data[s] = 0; m_to[s] = 1;
        end else begin
          m_age[s]++;
        end
      end
      if (bus.sel_en[s]) begin
        if (was_busy[s]) m_ovr[s] = 1;
        else if (!bus.wr_rd_s) begin
          m_pend[s] = 1; m_op[s] = bus.op_id; m_addr[s] = bus.addr; m_age[s] = 0;
        end
      end
      exp_busy[s] = was_busy[s] || m_pend[s] || m_ready[s];
      exp_ovr[s]  = m_ovr[s];
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.sel_en = '0; bus.addr = '0; bus.wr_rd_s = 1'b0; bus.op_id = '0;
    bus.rd_valid = '0; bus.rd_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.resp_full = 1'b0;
    rst_n = 1'b0;
    cycle(); cycle();
    rst_n = 1'b1;
    tests_run++;
    if (bus.resp_wr_en !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_en: got %b expected 0", bus.resp_wr_en); end
    tests_run++;
    if (bus.resp_frame !== 32'h0) begin tests_failed++; $display("FAIL reset_frame: got %h expected 0", bus.resp_frame); end
    tests_run++;
    if (bus.sw_busy !== 5'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", bus.sw_busy); end
    tests_run++;
    if (bus.err_overrun !== 5'b0) begin tests_failed++; $display("FAIL reset_overrun: got %b expected 0", bus.err_overrun); end
  endtask

  task automatic test_timeout();
    bus.sel_en = 5'b00001; bus.wr_rd_s = 1'b0; bus.op_id = 8'h22; bus.addr = 8'h05;
    cycle();
    idle_inputs();
    tests_run++;
    if (bus.sw_busy[0] !== 1'b1) begin tests_failed++; $display("FAIL timeout_busy: got %b expected 1", bus.sw_busy[0]); end
    for (int k = 1; k <= TO; k++) begin
      cycle();
      tests_run++;
      if (bus.resp_wr_en !== 1'b0) begin tests_failed++; $display("FAIL timeout_early_wr cycle %0d: got %b expected 0", k, bus.resp_wr_en); end
    end
    cycle();
    tests_run++;
    if (bus.resp_wr_en !== 1'b1) begin tests_failed++; $display("FAIL timeout_wr: got %b expected 1", bus.resp_wr_en); end
    tests_run++;
    if (bus.resp_frame !== 32'h22050010) begin tests_failed++; $display("FAIL timeout_frame: got %h expected 22050010", bus.resp_frame); end
    cycle();
    tests_run++;
    if (bus.sw_busy[0] !== 1'b0) begin tests_failed++; $display("FAIL timeout_busy_clear: got %b expected 0", bus.sw_busy[0]); end
  endtask

  task automatic test_read_normal();
    bus.sel_en = 5'b00100; bus.wr_rd_s = 1'b0; bus.addr = 8'h3A; bus.op_id = 8'h11;
    cycle();
    idle_inputs();
    tests_run++;
    if (bus.sw_busy[2] !== 1'b1) begin tests_failed++; $display("FAIL read_busy_set: got %b expected 1", bus.sw_busy[2]); end
    cycle(); cycle();
    bus.rd_valid = 5'b00100; bus.rd_data[2*W +: W] = 8'hC5;
    cycle();
    idle_inputs();
    tests_run++;
    if (bus.resp_wr_en !== 1'b0) begin tests_failed++; $display("FAIL read_wr_early: got %b expected 0", bus.resp_wr_en); end
    cycle();
    tests_run++;
    if (bus.resp_wr_en !== 1'b1) begin tests_failed++; $display("FAIL read_wr: got %b expected 1", bus.resp_wr_en); end
    tests_run++;
    if (bus.resp_frame !== 32'h113AC540) begin tests_failed++; $display("FAIL read_frame: got %h expected 113ac540", bus.resp_frame); end
    tests_run++;
    if (bus.sw_busy[2] !== 1'b1) begin tests_failed++; $display("FAIL read_busy_wr_cycle: got %b expected 1", bus.sw_busy[2]); end
    cycle();
    tests_run++;
    if (bus.resp_wr_en !== 1'b0 || bus.sw_busy[2] !== 1'b0) begin
      tests_failed++; $display("FAIL read_after: wr_en %b busy %b expected 0 0", bus.resp_wr_en, bus.sw_busy[2]);
    end
  endtask

  task automatic test_round_robin();
    int order[3] = '{3, 4, 1};
    bus.sel_en = 5'b11010; bus.wr_rd_s = 1'b0; bus.addr = 8'h10; bus.op_id = 8'h55;
    cycle();
    idle_inputs();
    bus.rd_valid = 5'b11010;
    bus.rd_data[1*W +: W] = 8'hA1; bus.rd_data[3*W +: W] = 8'hA3; bus.rd_data[4*W +: W] = 8'hA4;
    cycle();
    idle_inputs();
    for (int j = 0; j < 3; j++) begin
      cycle();
      tests_run++;
      if (bus.resp_wr_en !== 1'b1 || 32'(bus.resp_frame[7:5]) !== order[j]) begin
        tests_failed++; $display("FAIL rr_order %0d: wr_en %b idx %0d expected 1 idx %0d", j, bus.resp_wr_en, bus.resp_frame[7:5], order[j]);
      end
      tests_run++;
      if (bus.resp_frame !== exp_frame) begin tests_failed++; $display("FAIL rr_frame %0d: got %h expected %h", j, bus.resp_frame, exp_frame); end
    end
    cycle();
    tests_run++;
    if (bus.resp_wr_en !== 1'b0) begin tests_failed++; $display("FAIL rr_done: got %b expected 0", bus.resp_wr_en); end
  endtask

  task automatic test_backpressure();
    bus.resp_full = 1'b1;
    bus.sel_en = 5'b00110; bus.wr_rd_s = 1'b0; bus.addr = 8'h20; bus.op_id = 8'h66;
    cycle();
    idle_inputs();
    bus.rd_valid = 5'b00110; bus.rd_data[1*W +: W] = 8'hB1; bus.rd_data[2*W +: W] = 8'hB2;
    cycle();
    idle_inputs();
    for (int k = 0; k < 10; k++) begin
      cycle();
      tests_run++;
      if (bus.resp_wr_en !== 1'b0 || bus.sw_busy[2] !== 1'b1) begin
        tests_failed++; $display("FAIL bp_stall %0d: wr_en %b busy2 %b expected 0 1", k, bus.resp_wr_en, bus.sw_busy[2]);
      end
    end
    bus.resp_full = 1'b0;
    cycle();
    tests_run++;
    if (bus.resp_wr_en !== 1'b1 || bus.resp_frame !== 32'h6620B240) begin
      tests_failed++; $display("FAIL bp_first: wr_en %b frame %h expected 1 6620b240", bus.resp_wr_en, bus.resp_frame);
    end
    cycle();
    tests_run++;
    if (bus.resp_wr_en !== 1'b1 || bus.resp_frame !== 32'h6620B120) begin
      tests_failed++; $display("FAIL bp_second: wr_en %b frame %h expected 1 6620b120", bus.resp_wr_en, bus.resp_frame);
    end
    cycle();
    tests_run++;
    if (bus.resp_wr_en !== 1'b0) begin tests_failed++; $display("FAIL bp_end: got %b expected 0", bus.resp_wr_en); end
  endtask

  task automatic test_errors();
    bus.sel_en = 5'b01000; bus.wr_rd_s = 1'b1; bus.addr = 8'h01; bus.op_id = 8'hEE;
    cycle();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      cycle();
      tests_run++;
      if (bus.resp_wr_en !== 1'b0 || bus.sw_busy[3] !== 1'b0) begin
        tests_failed++; $display("FAIL err_write %0d: wr_en %b busy3 %b expected 0 0", k, bus.resp_wr_en, bus.sw_busy[3]);
      end
    end
    bus.sel_en = 5'b00010; bus.wr_rd_s = 1'b0; bus.addr = 8'h44; bus.op_id = 8'h33;
    cycle();
    bus.op_id = 8'h77; bus.addr = 8'h78;
    cycle();
    idle_inputs();
    tests_run++;
    if (bus.err_overrun !== 5'b00010) begin tests_failed++; $display("FAIL err_overrun: got %b expected 00010", bus.err_overrun); end
    bus.rd_valid = 5'b00010; bus.rd_data[1*W +: W] = 8'h99;
    cycle();
    idle_inputs();
    cycle();
    tests_run++;
    if (bus.resp_wr_en !== 1'b1 || bus.resp_frame !== 32'h33449920) begin
      tests_failed++; $display("FAIL err_opid_kept: wr_en %b frame %h expected 1 33449920", bus.resp_wr_en, bus.resp_frame);
    end
    bus.rd_valid = 5'b10000; bus.rd_data[4*W +: W] = 8'h5A;
    cycle();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      cycle();
      tests_run++;
      if (bus.resp_wr_en !== 1'b0 || bus.sw_busy[4] !== 1'b0) begin
        tests_failed++; $display("FAIL err_spurious_valid %0d: wr_en %b busy4 %b expected 0 0", k, bus.resp_wr_en, bus.sw_busy[4]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.resp_full = 1'b1;
    bus.sel_en = 5'b00101; bus.wr_rd_s = 1'b0; bus.addr = 8'h09; bus.op_id = 8'h88;
    cycle();
    idle_inputs();
    bus.rd_valid = 5'b00100; bus.rd_data[2*W +: W] = 8'h12;
    cycle();
    idle_inputs();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    bus.resp_full = 1'b0;
    tests_run++;
    if (bus.resp_wr_en !== 1'b0 || bus.resp_frame !== 32'h0 || bus.sw_busy !== 5'b0 || bus.err_overrun !== 5'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: wr_en %b frame %h busy %b ovr %b expected all 0", bus.resp_wr_en, bus.resp_frame, bus.sw_busy, bus.err_overrun);
    end
    bus.rd_valid = 5'b00001; bus.rd_data[0 +: W] = 8'h77;
    cycle();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      cycle();
      tests_run++;
      if (bus.resp_wr_en !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_no_frame %0d: got %b expected 0", k, bus.resp_wr_en); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bus.sel_en   = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b0;
      bus.wr_rd_s  = ($urandom_range(0, 3) == 0);
      bus.op_id    = 8'($urandom);
      bus.addr     = 8'($urandom);
      // Second half makes rd_valid rare so timeouts occur.
      if (c < 300) bus.rd_valid = ($urandom_range(0, 1) == 0) ? 5'($urandom) : 5'b0;
      else         bus.rd_valid = ($urandom_range(0, 15) == 0) ? 5'($urandom) : 5'b0;
      bus.rd_data  = 40'({$urandom(), $urandom()});
      bus.resp_full = ($urandom_range(0, 4) == 0);
      cycle();
      tests_run++;
      if (bus.resp_wr_en !== exp_wr || bus.resp_frame !== exp_frame) begin
        tests_failed++;
        $display("FAIL rand_out cycle %0d: wr_en %b frame %h expected %b %h", c, bus.resp_wr_en, bus.resp_frame, exp_wr, exp_frame);
      end
      tests_run++;
      if (bus.sw_busy !== exp_busy || bus.err_overrun !== exp_ovr) begin
        tests_failed++;
        $display("FAIL rand_status cycle %0d: busy %b ovr %b expected %b %b", c, bus.sw_busy, bus.err_overrun, exp_busy, exp_ovr);
      end
    end
    idle_inputs();
    bus.resp_full = 1'b0;
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_read_normal();
    test_round_robin();
    test_backpressure();
    test_errors();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/rx_collector.md
Name: rx_collector

Overview:
- Downstream neighbour of the TX scheduler, on the switch memory interface.
- Watches every switch access the scheduler issues (sel_en, addr, wr_rd_s, op_id) and tracks one outstanding read per switch instance.
- Collects each read result, or a timeout, into a FRAME_WIDTH response frame and writes it into the response FIFO.
- Drives sw_busy back to the scheduler so no new access is issued to a switch with a pending read.

Parameters:
NUM_SW_INST, 5, number of switch instances / tracking slots
W_WIDTH, 8, address and data width of the switch interface
FRAME_WIDTH, 32, response frame width; must be >= 8+2*W_WIDTH+4
TIMEOUT, 16, cycles a slot waits for rd_valid before reporting a timeout (>=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
sel_en  in  NUM_SW_INST  per-switch access strobe from the scheduler
addr  in  W_WIDTH  access address from the scheduler
wr_rd_s  in  1  1=write, 0=read
op_id  in  8  operation tag from the scheduler
rd_valid  in  NUM_SW_INST  per-switch read-data valid
rd_data  in  NUM_SW_INST*W_WIDTH  per-switch read data; slot i uses bits [i*W_WIDTH +: W_WIDTH]
resp_full  in  1  response FIFO full
resp_wr_en  out  1  response FIFO write strobe
resp_frame  out  FRAME_WIDTH  response frame
sw_busy  out  NUM_SW_INST  slot i is not IDLE; goes to the scheduler
err_overrun  out  NUM_SW_INST  sticky: access arrived while slot i was not IDLE

Behaviour:
- Reset (rst_n=0 at a clock edge): all slots IDLE; timers, op_id, addr and data registers 0; rr pointer 0; resp_wr_en=0; resp_frame=0; sw_busy=0; err_overrun=0.
- Reset mid-operation discards pending reads and undelivered frames.
- Every output is registered.
- Slot FSM, one per switch i:
  - IDLE -> WAIT: sel_en[i]=1 and wr_rd_s=0. Capture op_id and addr; clear the timer.
  - IDLE: sel_en[i]=1 with wr_rd_s=1 (write) is ignored; no response frame.
  - WAIT -> DONE: rd_valid[i]=1. Capture rd_data slice; to_flag=0.
  - WAIT -> DONE on timeout: the timer reaches TIMEOUT-1 with rd_valid[i]=0. Data=0; to_flag=1. rd_valid in that same cycle wins over the timeout.
  - DONE -> IDLE: the slot is granted and its frame is written.
- sw_busy[i]=1 while slot i is in WAIT or DONE.
  - The cycle after a read strobe, sw_busy[i]=1.
  - The cycle after the frame write, sw_busy[i]=0.
- Error and spurious cases:
  - sel_en[i] while slot i is not IDLE: ignored; err_overrun[i] set, sticky until reset.
  - rd_valid[i] outside WAIT: ignored.
  - Multiple sel_en bits in one cycle: each addressed slot captures independently.
- Output arbitration, evaluated each cycle:
  - Round-robin among DONE slots, searching from the rr pointer upward with modulo NUM_SW_INST.
  - If a slot is granted and resp_full=0: next cycle resp_wr_en=1 and resp_frame = that slot's frame; slot -> IDLE; rr pointer = grant+1 mod N.
  - Otherwise resp_wr_en=0 next cycle, resp_frame holds its last value, and the pointer does not move.
  - resp_full=1 stalls the output; slots stay DONE indefinitely and no frame is dropped.
- Frame layout, MSB first:
  - [FRAME_WIDTH-1 -: 8] op_id
  - next W_WIDTH: addr
  - next W_WIDTH: rd_data
  - next 3: slot index
  - next 1: to_flag
  - remaining LSBs: 0
  - Default 32-bit: [31:24] op_id, [23:16] addr, [15:8] data, [7:5] idx, [4] to_flag, [3:0] 0.
- Latency: rd_valid at cycle t -> DONE at t+1 -> resp_wr_en=1 at t+2, given grant and resp_full=0.
- Throughput: at most one frame per cycle.
- Timer width: $clog2(TIMEOUT); it never wraps because the slot leaves WAIT at TIMEOUT-1.

Decomposition:
- Shared package, rx_pkg:
  - slot state enum IDLE/WAIT/DONE
  - frame field offset/width localparams (OPID_MSB, ADDR_LSB, DATA_LSB, IDX_LSB, TO_BIT)
  - the WR/RD encoding of wr_rd_s
- One sub-module, rr_arbiter: parameter N; inputs req[N], advance; outputs grant one-hot, grant_idx; holds the pointer.
- Slot logic stays in rx_collector as a generate loop.

Test Plan:
- Read, normal: sel_en=5'b00100, wr_rd_s=0, addr=0x3A, op_id=0x11; rd_valid[2] with data 0xC5 three cycles later -> two cycles after rd_valid, resp_wr_en=1 for 1 cycle, resp_frame=0x113AC540; sw_busy[2] high from strobe+1 through the write cycle.
- Timeout: read on slot 0, op_id=0x22, addr=0x05, no rd_valid -> after TIMEOUT=16 cycles, frame=0x22050010 (to_flag=1, data=0).
- Round-robin: slots 1, 3, 4 reach DONE in the same cycle with pointer=3 -> frames written in order idx 3, 4, 1 on consecutive cycles; pointer ends at 2.
- Backpressure: resp_full=1 for 10 cycles with slot 2 DONE -> resp_wr_en stays 0 and sw_busy[2] stays 1; frame written the cycle after resp_full drops; no loss.
- Errors: write strobe (wr_rd_s=1) -> no frame. Second read to a WAIT slot 1 -> err_overrun[1]=1 and captured op_id unchanged. rd_valid[4] while slot 4 IDLE -> no effect.
- Reset mid-operation: rst_n=0 for 1 cycle with slots 0 and 2 in WAIT/DONE -> next cycle all outputs 0; later rd_valid[0] produces no frame.
